seven_bit_serial_subtractor: RTL and testbench
==============================================

Name: seven_bit_serial_subtractor

Overview:
- Pushbutton-driven 7-bit unsigned subtractor for the lab board; the counterpart of the team's parallel adder.
- Operands are loaded nibble-wise from the switches. The difference A - B is computed bit-serially, LSB first, one bit per clock.
- The result is read back nibble-wise on four LEDs, selected by a pushbutton. This is the readout path the adder lacks.
- Sits between the board switch/button pins and the LED pins; all logic runs on the single board clock.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive clk cycles a synchronised button level must hold before it is accepted. Range 1..2^20.

Ports:
- clk  input  1  board clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- pb1  input  1  load A[3:0] <= y[3:0]
- pb2  input  1  load A[6:4] <= y[2:0]
- pb3  input  1  load B[3:0] <= y[3:0]
- pb4  input  1  load B[6:4] <= y[2:0]
- pb_go  input  1  start subtraction
- pb_sel  input  1  toggle LED readout nibble
- y  input  4  slide-switch data
- z  output  7  registered difference A - B mod 128
- bout  output  1  registered borrow out; 1 iff A < B (unsigned)
- led  output  4  sel=0: z[3:0]; sel=1: {bout, z[6:4]}
- busy  output  1  high during computation
- done  output  1  one-cycle pulse when z/bout update

Behaviour:
- Reset (rst=1 at a clk edge):
  - A=B=0, z=0, bout=0, sel=0, done=0, busy=0.
  - State IDLE; debouncers cleared to "released"; shift registers and borrow cleared.
  - Applies equally in mid-computation; a partial result is discarded and z stays 0.
- Button path (identical for all six buttons):
  - 2-FF synchroniser feeds a debounce counter.
  - The stable level flips only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  - A one-cycle press pulse is generated on the stable 0->1 transition. Release generates nothing.
  - Holding a button produces exactly one pulse.
  - Press pulse latency from a clean pin edge = 2 + DEBOUNCE_CYCLES + 1 cycles.
- Loads:
  - Performed on press pulses, only in IDLE. Press pulses arriving in CALC are dropped, not queued.
  - Hi-nibble loads ignore y[3].
  - Several press pulses in the same cycle each perform their own load.
- FSM states: IDLE, CALC.
  - IDLE -> CALC on a pb_go pulse. On that edge: copy A/B into shift registers, borrow <= 0, bit index <= 0.
  - CALC, each cycle:
    - d = a_i ^ b_i ^ borrow
    - borrow <= (~a_i & b_i) | (~(a_i ^ b_i) & borrow)
    - d is shifted into the result shift register; index increments.
  - CALC -> IDLE after exactly 7 CALC cycles. On that final edge, z and bout are loaded and done=1 for the following cycle only.
- Latency and flags:
  - busy=1 exactly during the 7 CALC cycles; done rises in the cycle after busy falls.
  - z/bout hold their previous value throughout CALC; there is no partial-result visibility.
  - pb_go during CALC is ignored.
  - pb_go together with a load pulse in the same IDLE cycle: the load happens AND the computation starts with the pre-load operand values.
- Readout:
  - A pb_sel press pulse toggles sel in any state.
  - led is combinational from sel, z and bout.
- Arithmetic: z = (A - B) mod 128; bout = borrow after bit 6. Equal operands give z=0, bout=0.

Test Plan:
- DEBOUNCE_CYCLES=4; reset; load A=42 (pb1 y=0xA, pb2 y=0x2) and B=15 (pb3 y=0xF, pb4 y=0x0); pb_go -> busy high 7 cycles, then done pulse; z=27 (0x1B), bout=0, led=0xB; press pb_sel -> led=0x1.
- A=5, B=9 -> z=124 (0x7C), bout=1; led after one pb_sel press = 0xF.
- A=127, B=127 -> z=0, bout=0; A=0, B=127 -> z=1, bout=1.
- pb1 bouncing (pulses of 1-3 cycles, shorter than DEBOUNCE_CYCLES), then held for 50 cycles with y=0x3 -> exactly one load, A[3:0]=3; no further loads while held.
- Mid-CALC, press pb3 with y=0x0 and press pb_go -> result still uses the old B; B unchanged after done; no second computation starts.
- Assert rst at the 4th CALC cycle -> next cycle busy=0, z=0, bout=0, A=B=0, done never pulses.

Source files
------------

// File: rtl/seven_bit_serial_subtractor.sv
// seven_bit_serial_subtractor: debounced pushbutton loads, bit-serial A-B, nibble LED readout
module seven_bit_serial_subtractor #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pb1,
  input  logic       pb2,
  input  logic       pb3,
  input  logic       pb4,
  input  logic       pb_go,
  input  logic       pb_sel,
  input  logic [3:0] y,
  output logic [6:0] z,
  output logic       bout,
  output logic [3:0] led,
  output logic       busy,
  output logic       done
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  typedef enum logic {IDLE, CALC} state_t;
  state_t state;
  logic [5:0] pins, s1, s2, stable, press;
  logic [CW-1:0] cnt [6];
  logic [6:0] a, b, sa, sb, r;
  logic [2:0] idx;
  logic br, sel, d, nbr;
  assign pins = {pb_sel, pb_go, pb4, pb3, pb2, pb1};
  assign d = sa[0] ^ sb[0] ^ br;
  assign nbr = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  assign busy = state == CALC;
  assign led = sel ? {bout, z[6:4]} : z[3:0];
  // any sample equal to the stable level restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      stable <= '0;
      press <= '0;
      for (int i = 0; i < 6; i++) cnt[i] <= '0;
    end else begin
      s1 <= pins;
      s2 <= s1;
      for (int i = 0; i < 6; i++) begin
        press[i] <= 1'b0;
        if (s2[i] == stable[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt[i] <= '0;
          stable[i] <= s2[i];
          press[i] <= s2[i];
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      sa <= '0;
      sb <= '0;
      r <= '0;
      br <= 1'b0;
      idx <= '0;
      z <= '0;
      bout <= 1'b0;
      sel <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (press[5]) sel <= ~sel;
      if (state == IDLE) begin
        if (press[0]) a[3:0] <= y;
        if (press[1]) a[6:4] <= y[2:0];
        if (press[2]) b[3:0] <= y;
        if (press[3]) b[6:4] <= y[2:0];
        // operands captured here are the pre-load values when a load coincides
        if (press[4]) begin
          sa <= a;
          sb <= b;
          br <= 1'b0;
          idx <= '0;
          state <= CALC;
        end
      end else begin
        sa <= sa >> 1;
        sb <= sb >> 1;
        r <= {d, r[6:1]};
        br <= nbr;
        idx <= idx + 1'b1;
        if (idx == 3'd6) begin
          state <= IDLE;
          z <= {d, r[6:1]};
          bout <= nbr;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_seven_bit_serial_subtractor.sv
// tb_seven_bit_serial_subtractor: directed checks; a second instance with 1-cycle debounce exercises mid-CALC presses
module tb_seven_bit_serial_subtractor;
  logic clk = 0, rst = 1;
  logic [5:0] pb = '0;
  logic [3:0] y = '0;
  logic [6:0] z, z1;
  logic [3:0] led, led1;
  logic bout, busy, done, bout1, busy1, done1;
  int ntests = 0, nfail = 0, nb = 0, nd = 0, np = 0, nb1 = 0, nd1 = 0;
  seven_bit_serial_subtractor #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .pb1(pb[0]), .pb2(pb[1]), .pb3(pb[2]), .pb4(pb[3]),
    .pb_go(pb[4]), .pb_sel(pb[5]), .y(y), .z(z), .bout(bout), .led(led),
    .busy(busy), .done(done)
  );
  seven_bit_serial_subtractor #(.DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .pb1(pb[0]), .pb2(pb[1]), .pb3(pb[2]), .pb4(pb[3]),
    .pb_go(pb[4]), .pb_sel(pb[5]), .y(y), .z(z1), .bout(bout1), .led(led1),
    .busy(busy1), .done(done1)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (busy) nb++;
    if (done) nd++;
    if (dut.press[0]) np++;
    if (busy1) nb1++;
    if (done1) nd1++;
  end
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic press(int i, logic [3:0] v);
    y = v;
    pb[i] = 1'b1;
    step(8);
    pb[i] = 1'b0;
    step(9);
  endtask
  task automatic go(string tag, logic [6:0] ez, logic eb);
    logic [6:0] z0;
    bit seen;
    z0 = z;
    seen = 0;
    nb = 0;
    nd = 0;
    pb[4] = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      if (busy && !seen) begin
        check({tag, "_hold"}, z, z0);
        seen = 1;
      end
      step(1);
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_low"}, busy, 0);
    pb[4] = 1'b0;
    step(12);
    check({tag, "_busy_cycles"}, nb, 7);
    check({tag, "_done_pulses"}, nd, 1);
    check({tag, "_z"}, z, ez);
    check({tag, "_bout"}, bout, eb);
  endtask
  initial begin
    step(3);
    check("rst_z", z, 0);
    check("rst_bout", bout, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_led", led, 0);
    check("rst_a", dut.a, 0);
    check("rst_b", dut.b, 0);
    rst = 0;
    step(2);
    press(0, 4'hA); press(1, 4'h2); press(2, 4'hF); press(3, 4'h0);
    check("load_a42", dut.a, 42);
    check("load_b15", dut.b, 15);
    go("s42_15", 7'd27, 1'b0);
    check("led_lo_27", led, 4'hB);
    press(5, 4'h0);
    check("led_hi_27", led, 4'h1);
    press(5, 4'h0);
    check("led_back_27", led, 4'hB);
    press(0, 4'h5); press(1, 4'h0); press(2, 4'h9); press(3, 4'h0);
    go("s5_9", 7'd124, 1'b1);
    check("led_lo_124", led, 4'hC);
    press(5, 4'h0);
    check("led_hi_124", led, 4'hF);
    press(5, 4'h0);
    press(0, 4'hF); press(1, 4'hF); press(2, 4'hF); press(3, 4'h7);
    check("load_a127", dut.a, 127);
    check("load_b127", dut.b, 127);
    go("s127_127", 7'd0, 1'b0);
    press(0, 4'h0); press(1, 4'h0);
    go("s0_127", 7'd1, 1'b1);
    check("led_lo_1", led, 4'h1);
    y = 4'h3;
    np = 0;
    pb[0] = 1; step(2); pb[0] = 0; step(1);
    pb[0] = 1; step(3); pb[0] = 0; step(2);
    pb[0] = 1; step(1); pb[0] = 0; step(3);
    pb[0] = 1; step(50);
    check("bounce_pulses", np, 1);
    check("bounce_a", dut.a, 3);
    pb[0] = 0; step(10);
    check("bounce_pulses_rel", np, 1);
    check("bounce_a_rel", dut.a, 3);
    y = 4'h0;
    step(2);
    nb = 0; nb1 = 0; nd1 = 0;
    pb[4] = 1; step(1);
    pb[4] = 0; step(2);
    pb[2] = 1; step(1);
    pb[2] = 0; pb[4] = 1; step(1);
    pb[4] = 0; step(30);
    check("mid_busy_cycles", nb1, 7);
    check("mid_done_pulses", nd1, 1);
    check("mid_z", z1, 4);
    check("mid_bout", bout1, 1);
    check("mid_b_kept", dut1.b, 127);
    check("short_go_ignored", nb, 0);
    check("short_pb3_ignored", dut.b, 127);
    check("short_z_kept", z, 1);
    nd = 0;
    pb[4] = 1;
    for (int k = 0; k < 30 && !busy; k++) step(1);
    check("rst_calc_busy", busy, 1);
    pb[4] = 0;
    step(3);
    rst = 1;
    step(1);
    check("midrst_busy", busy, 0);
    check("midrst_z", z, 0);
    check("midrst_bout", bout, 0);
    check("midrst_a", dut.a, 0);
    check("midrst_b", dut.b, 0);
    rst = 0;
    step(20);
    check("midrst_no_done", nd, 0);
    check("midrst_idle", busy, 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
